pipeline_ctrl: RTL

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

---
 rtl/pipeline_ctrl.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/pipeline_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_ctrl
// Purpose  : Hazard/stall/flush controller for a 5-stage in-order pipeline.
//            Produces pipeline-register write enables and bubble-insert
//            (flush) strobes from hazard inputs, and keeps saturating
//            stall/flush performance counters.
// Ports    : clk, rst (async, active high)
//            load_use_in, redirect_in, imem_ready_in, dmem_req_in,
//            dmem_ready_in, cnt_clr_in                      - hazard/status in
//            pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en - write enables
//            if_id_flush, id_ex_flush                        - bubble strobes
//            stall_count, flush_count [CNT_W]                - perf counters
// Revision : 1.0 - initial release
// ============================================================================
module pipeline_ctrl #(
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_use_in,
  input  logic             redirect_in,
  input  logic             imem_ready_in,
  input  logic             dmem_req_in,
  input  logic             dmem_ready_in,
  input  logic             cnt_clr_in,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    MEM_WAIT = 2'd2,
    FLUSH    = 2'd3
  } state_t;

  localparam logic [3:0]       FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

  state_t           state_q, state_d;
  logic [3:0]       fcnt_q, fcnt_d;
  logic [CNT_W-1:0] stall_count_q, stall_count_d;
  logic [CNT_W-1:0] flush_count_q, flush_count_d;
  logic             redirect_acc;
  logic             stall_inc;

  always_comb begin
    pc_en        = 1'b0;
    if_id_en     = 1'b0;
    id_ex_en     = 1'b0;
    ex_mem_en    = 1'b0;
    mem_wb_en    = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    state_d      = state_q;
    fcnt_d       = fcnt_q;
    redirect_acc = 1'b0;

    case (state_q)
      IDLE: begin
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
        state_d     = RUN;
      end

      FLUSH: begin
        if (dmem_req_in && !dmem_ready_in) begin
          // Frozen: stay in FLUSH with the bubble count held so the
          // remaining bubbles are still issued once memory completes.
          state_d = FLUSH;
        end else if (redirect_in) begin
          {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = 5'b11111;
          if_id_flush  = 1'b1;
          id_ex_flush  = 1'b1;
          redirect_acc = 1'b1;
          fcnt_d       = FLUSH_LOAD;
        end else begin
          {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = 5'b11111;
          if_id_flush = 1'b1;
          fcnt_d      = fcnt_q - 4'd1;
          if (fcnt_q <= 4'd1) begin
            state_d = RUN;
          end
        end
      end

      default: begin  // RUN and MEM_WAIT share the hazard priority chain
        // In MEM_WAIT the access is already outstanding, so only ready matters.
        if ((state_q == MEM_WAIT) ? !dmem_ready_in
                                  : (dmem_req_in && !dmem_ready_in)) begin
          state_d = MEM_WAIT;
        end else if (redirect_in) begin
          // pc_en stays high so the target is captured even without fetch data.
          {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = 5'b11111;
          if_id_flush  = 1'b1;
          id_ex_flush  = 1'b1;
          redirect_acc = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            state_d = FLUSH;
            fcnt_d  = FLUSH_LOAD;
          end else begin
            state_d = RUN;
          end
        end else begin
          {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = 5'b11111;
          state_d = RUN;
          if (load_use_in) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
          end else if (!imem_ready_in) begin
            pc_en       = 1'b0;
            if_id_flush = 1'b1;
          end
        end
      end
    endcase
  end

  assign stall_inc = !pc_en && (state_q != IDLE);

  always_comb begin
    stall_count_d = stall_count_q;
    flush_count_d = flush_count_q;
    if (cnt_clr_in) begin
      stall_count_d = '0;
      flush_count_d = '0;
    end else begin
      if (stall_inc && (stall_count_q != CNT_MAX)) begin
        stall_count_d = stall_count_q + CNT_ONE;
      end
      if (redirect_acc && (flush_count_q != CNT_MAX)) begin
        flush_count_d = flush_count_q + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      fcnt_q        <= 4'd0;
      stall_count_q <= '0;
      flush_count_q <= '0;
    end else begin
      state_q       <= state_d;
      fcnt_q        <= fcnt_d;
      stall_count_q <= stall_count_d;
      flush_count_q <= flush_count_d;
    end
  end

  assign stall_count = stall_count_q;
  assign flush_count = flush_count_q;

endmodule
`default_nettype wire
